store_write_buffer: RTL and testbench

- Committed-store buffer directly downstream of the store queue.
- Accepts retired stores (word-block address, byte enables, data) and holds them in a small circular FIFO.
- Drains them in order to the D-cache over a valid/ack handshake.
- Merges consecutive stores to the same block, and answers load forwarding lookups so loads see not-yet-written store data.

---
 rtl/store_write_buffer.sv | 145 ++++++++++++++
 tb/tb_store_write_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Committed-store write buffer between the store queue and the D-cache.
// Holds retired stores in order, merges same-block stores, forwards to loads.
module store_write_buffer #(
    parameter int ENTRY_NUM   = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int BLOCK_WIDTH = 32,
    parameter int BYTE_NUM    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [ADDR_WIDTH-1:0]  enq_addr,
    input  logic [BYTE_NUM-1:0]    enq_byte_we,
    input  logic [BLOCK_WIDTH-1:0] enq_data,
    output logic                   dc_req_valid,
    output logic [ADDR_WIDTH-1:0]  dc_req_addr,
    output logic [BYTE_NUM-1:0]    dc_req_byte_we,
    output logic [BLOCK_WIDTH-1:0] dc_req_data,
    input  logic                   dc_ack,
    input  logic [ADDR_WIDTH-1:0]  ld_addr,
    input  logic [BYTE_NUM-1:0]    ld_byte_re,
    output logic                   ld_fwd_hit,
    output logic [BLOCK_WIDTH-1:0] ld_fwd_data,
    output logic                   ld_fwd_conflict,
    output logic                   empty
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENTRY_NUM);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic                   r_valid [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0]  r_addr  [ENTRY_NUM];
    logic [BYTE_NUM-1:0]    r_be    [ENTRY_NUM];
    logic [BLOCK_WIDTH-1:0] r_data  [ENTRY_NUM];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic [PTR_W-1:0] w_young;
    logic             w_nonempty;
    logic             w_merge_ok;
    logic             w_fire;
    logic             w_merge;
    logic             w_alloc;
    logic             w_deq;
    logic             w_match;
    logic [PTR_W-1:0] w_sel;
    logic [PTR_W-1:0] w_idx;
    logic             w_cover;

    assign w_young    = r_tail - 1'b1;
    assign w_nonempty = (r_count != '0);

    // Merge only into the youngest entry, and only when it is not the head,
    // so the entry being presented to the D-cache never changes under it.
    assign w_merge_ok = (r_count >= TWO_CNT) && (w_young != r_head) &&
                        r_valid[w_young] && (enq_addr == r_addr[w_young]);

    assign enq_ready = (r_count < FULL_CNT) || w_merge_ok;
    assign w_fire    = enq_valid && enq_ready;
    assign w_merge   = w_fire && w_merge_ok;
    assign w_alloc   = w_fire && !w_merge_ok;
    assign w_deq     = dc_ack && w_nonempty;

    assign empty          = !w_nonempty;
    assign dc_req_valid   = w_nonempty;
    assign dc_req_addr    = w_nonempty ? r_addr[r_head] : '0;
    assign dc_req_byte_we = w_nonempty ? r_be[r_head]   : '0;
    assign dc_req_data    = w_nonempty ? r_data[r_head] : '0;

    // Entry array: retire head on ack, allocate at tail, merge into youngest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= '0;
                r_be[i]    <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= enq_addr;
                r_be[r_tail]    <= enq_byte_we;
                r_data[r_tail]  <= enq_data;
            end
            if (w_merge) begin
                r_be[w_young] <= r_be[w_young] | enq_byte_we;
                for (int b = 0; b < BYTE_NUM; b++) begin
                    if (enq_byte_we[b]) begin
                        r_data[w_young][8*b +: 8] <= enq_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Pointers wrap naturally; occupancy is tracked by the counter alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_alloc, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Walk from oldest to youngest so the last match found is the youngest.
    always_comb begin
        w_match = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (r_valid[w_idx] && (r_addr[w_idx] == ld_addr)) begin
                w_match = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_cover = ((ld_byte_re & ~r_be[w_sel]) == '0);

    assign ld_fwd_hit      = w_match && (ld_byte_re != '0) && w_cover;
    assign ld_fwd_conflict = w_match && (ld_byte_re != '0) && !w_cover;
    assign ld_fwd_data     = ld_fwd_hit ? r_data[w_sel] : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: drain and load-forward results
// are checked by a monitor against scoreboard queues filled by the stimulus.
module tb_store_write_buffer;

    typedef struct packed {
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } dc_t;

    typedef struct packed {
        logic        hit;
        logic        conf;
        logic [31:0] d;
    } ld_t;

    logic        clk;
    logic        rst_n;
    logic        enq_valid;
    logic        enq_ready;
    logic [29:0] enq_addr;
    logic [3:0]  enq_byte_we;
    logic [31:0] enq_data;
    logic        dc_req_valid;
    logic [29:0] dc_req_addr;
    logic [3:0]  dc_req_byte_we;
    logic [31:0] dc_req_data;
    logic        dc_ack;
    logic [29:0] ld_addr;
    logic [3:0]  ld_byte_re;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_fwd_conflict;
    logic        empty;

    dc_t exp_q[$];
    ld_t ld_q[$];
    logic ld_chk;
    int n_vec;
    int n_err;

    store_write_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_addr        (enq_addr),
        .enq_byte_we     (enq_byte_we),
        .enq_data        (enq_data),
        .dc_req_valid    (dc_req_valid),
        .dc_req_addr     (dc_req_addr),
        .dc_req_byte_we  (dc_req_byte_we),
        .dc_req_data     (dc_req_data),
        .dc_ack          (dc_ack),
        .ld_addr         (ld_addr),
        .ld_byte_re      (ld_byte_re),
        .ld_fwd_hit      (ld_fwd_hit),
        .ld_fwd_data     (ld_fwd_data),
        .ld_fwd_conflict (ld_fwd_conflict),
        .empty           (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [29:0] a, input logic [3:0] be,
                        input logic [31:0] d);
        dc_t e;
        e.a  = a;
        e.be = be;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic enq(input logic [29:0] a, input logic [3:0] be,
                       input logic [31:0] d);
        enq_valid   = 1'b1;
        enq_addr    = a;
        enq_byte_we = be;
        enq_data    = d;
        #1;
        chk("enq_ready", {63'd0, enq_ready}, 64'd1);
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
    endtask

    task automatic ld(input logic [29:0] a, input logic [3:0] re,
                      input logic h, input logic c, input logic [31:0] d);
        ld_t e;
        e.hit  = h;
        e.conf = c;
        e.d    = d;
        ld_q.push_back(e);
        ld_addr    = a;
        ld_byte_re = re;
        ld_chk     = 1'b1;
        tick();
        ld_chk = 1'b0;
    endtask

    task automatic drain_all;
        dc_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (empty) break;
            tick();
        end
        dc_ack = 1'b0;
        chk("drain_empty", {63'd0, empty}, 64'd1);
    endtask

    // Scoreboard monitor: compares every accepted D-cache request and
    // every flagged load lookup against the queued expectations.
    always @(negedge clk) begin
        if (rst_n && dc_ack && dc_req_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL drain_extra: got %h/%h/%h expected none",
                         dc_req_addr, dc_req_byte_we, dc_req_data);
            end else begin
                dc_t e;
                e = exp_q.pop_front();
                if ({dc_req_addr, dc_req_byte_we, dc_req_data} !== e) begin
                    n_err++;
                    $display("FAIL drain: got %h/%h/%h expected %h/%h/%h",
                             dc_req_addr, dc_req_byte_we, dc_req_data,
                             e.a, e.be, e.d);
                end
            end
        end
        if (ld_chk) begin
            n_vec++;
            if (ld_q.size() == 0) begin
                n_err++;
                $display("FAIL ld_extra: got lookup with no expectation");
            end else begin
                ld_t l;
                l = ld_q.pop_front();
                if ({ld_fwd_hit, ld_fwd_conflict, ld_fwd_data} !==
                    {l.hit, l.conf, l.d}) begin
                    n_err++;
                    $display("FAIL ld_fwd: got hit=%b conf=%b data=%h expected hit=%b conf=%b data=%h",
                             ld_fwd_hit, ld_fwd_conflict, ld_fwd_data,
                             l.hit, l.conf, l.d);
                end
            end
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        ld_chk      = 1'b0;
        rst_n       = 1'b0;
        enq_valid   = 1'b0;
        enq_addr    = '0;
        enq_byte_we = '0;
        enq_data    = '0;
        dc_ack      = 1'b0;
        ld_addr     = '0;
        ld_byte_re  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, enq_ready}, 64'd1);
        chk("rst_valid", {63'd0, dc_req_valid}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_data", {32'd0, dc_req_data}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-stream discards buffered stores asynchronously
        enq(30'h123, 4'hF, 32'h1111_1111);
        enq(30'h124, 4'hF, 32'h2222_2222);
        chk("pre_rst_valid", {63'd0, dc_req_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", {63'd0, dc_req_valid}, 64'd0);
        chk("async_empty", {63'd0, empty}, 64'd1);
        chk("async_ready", {63'd0, enq_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", {63'd0, dc_req_valid}, 64'd0);
        end

        // Single store, held 5 cycles without ack
        push(30'h100, 4'hF, 32'hDEAD_BEEF);
        enq(30'h100, 4'hF, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {63'd0, dc_req_valid}, 64'd1);
            chk("hold_addr", {34'd0, dc_req_addr}, 64'h100);
            chk("hold_data", {32'd0, dc_req_data}, 64'hDEAD_BEEF);
            tick();
        end
        drain_all();

        // Fill to full, then ack with a pending new-address store
        push(30'h10, 4'hF, 32'hAAAA_0001);
        enq(30'h10, 4'hF, 32'hAAAA_0001);
        push(30'h20, 4'hF, 32'hBBBB_0002);
        enq(30'h20, 4'hF, 32'hBBBB_0002);
        push(30'h30, 4'hF, 32'hCCCC_0003);
        enq(30'h30, 4'hF, 32'hCCCC_0003);
        push(30'h40, 4'hF, 32'hDDDD_0004);
        enq(30'h40, 4'hF, 32'hDDDD_0004);
        enq_valid   = 1'b1;
        enq_addr    = 30'h50;
        enq_byte_we = 4'hF;
        enq_data    = 32'hEEEE_0005;
        #1;
        chk("full_ready", {63'd0, enq_ready}, 64'd0);
        dc_ack = 1'b1;
        #1;
        chk("full_ack_ready", {63'd0, enq_ready}, 64'd0);
        push(30'h50, 4'hF, 32'hEEEE_0005);
        tick();
        chk("freed_ready", {63'd0, enq_ready}, 64'd1);
        tick();
        enq_valid = 1'b0;
        drain_all();

        // Merge into youngest; later same-as-head address allocates
        push(30'h200, 4'h1, 32'h0000_0011);
        enq(30'h200, 4'h1, 32'h0000_0011);
        push(30'h300, 4'h3, 32'h0000_3322);
        enq(30'h300, 4'h1, 32'h0000_0022);
        enq(30'h300, 4'h2, 32'h0000_3300);
        push(30'h200, 4'h4, 32'h0044_0000);
        enq(30'h200, 4'h4, 32'h0044_0000);
        push(30'h800, 4'h9, 32'h8000_0001);
        enq(30'h800, 4'h8, 32'h8000_0000);
        enq_addr = 30'h900;
        #1;
        chk("merged_full_ready", {63'd0, enq_ready}, 64'd0);
        enq(30'h800, 4'h1, 32'h0000_0001);

        // Forwarding against the held entries
        ld(30'h300, 4'h3, 1'b1, 1'b0, 32'h0000_3322);
        ld(30'h300, 4'hF, 1'b0, 1'b1, 32'h0);
        ld(30'h400, 4'hF, 1'b0, 1'b0, 32'h0);
        ld(30'h200, 4'h4, 1'b1, 1'b0, 32'h0044_0000);
        ld(30'h200, 4'h1, 1'b0, 1'b1, 32'h0);
        ld(30'h300, 4'h0, 1'b0, 1'b0, 32'h0);
        drain_all();

        // Youngest of two matching entries wins
        push(30'h500, 4'hF, 32'h0000_AAAA);
        enq(30'h500, 4'hF, 32'h0000_AAAA);
        push(30'h600, 4'hF, 32'h0000_0001);
        enq(30'h600, 4'hF, 32'h0000_0001);
        push(30'h500, 4'hF, 32'h0000_BBBB);
        enq(30'h500, 4'hF, 32'h0000_BBBB);
        ld(30'h500, 4'h3, 1'b1, 1'b0, 32'h0000_BBBB);
        drain_all();

        // With one entry the youngest is the head: no merge
        push(30'h700, 4'h1, 32'h0000_0007);
        enq(30'h700, 4'h1, 32'h0000_0007);
        push(30'h700, 4'h2, 32'h0000_0800);
        enq(30'h700, 4'h2, 32'h0000_0800);
        drain_all();

        tick();
        chk("exp_q_left", 64'(exp_q.size()), 64'd0);
        chk("ld_q_left", 64'(ld_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
